// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states, grant bit positions
// and the arbitration rule applied from idle or on a handoff.
package wb_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GNT_I = 2'd1;
  localparam logic [1:0] ARB_GNT_D = 2'd2;

  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  // D wins an uncontested tie after reset; afterwards the previous loser wins.
  function automatic logic [1:0] arb_pick(input logic i_req, input logic d_req,
                                          input logic last_was_d);
    logic [1:0] pick;
    pick = ARB_IDLE;
    if (i_req && d_req) pick = last_was_d ? ARB_GNT_I : ARB_GNT_D;
    else if (d_req)     pick = ARB_GNT_D;
    else if (i_req)     pick = ARB_GNT_I;
    return pick;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-timeout counter: counts strobed cycles without ack and flags a one-cycle error
// on the final allowed cycle. TIMEOUT_CYCLES=0 disables it.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_WIDTH       = 9
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic err_o
);

  localparam int                  LAST_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_WIDTH-1:0] LAST    = TO_WIDTH'(LAST_I);
  localparam bit                  ENABLED = (TIMEOUT_CYCLES > 0);

  logic [TO_WIDTH-1:0] count;
  logic                expire;

  assign expire = ENABLED && run_i && (count == LAST);
  assign err_o  = expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear_i || !run_i || expire) begin
      count <= '0;
    end else begin
      count <= count + TO_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (I, D) to one-slave Wishbone arbiter with grants held for the whole cycle,
// direct handoff on cyc drop, and a timeout watchdog that returns err to the granted master.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_WIDTH       = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] wb_I_adr_i,
  input  logic [31:0] wb_I_dat_i,
  input  logic [3:0]  wb_I_sel_i,
  input  logic        wb_I_we_i,
  input  logic        wb_I_cyc_i,
  input  logic        wb_I_stb_i,
  output logic [31:0] wb_I_dat_o,
  output logic        wb_I_ack_o,
  output logic        wb_I_err_o,

  input  logic [31:0] wb_D_adr_i,
  input  logic [31:0] wb_D_dat_i,
  input  logic [3:0]  wb_D_sel_i,
  input  logic        wb_D_we_i,
  input  logic        wb_D_cyc_i,
  input  logic        wb_D_stb_i,
  output logic [31:0] wb_D_dat_o,
  output logic        wb_D_ack_o,
  output logic        wb_D_err_o,

  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,

  output logic [1:0]  gnt_o
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_was_d;
  logic       grant_i;
  logic       grant_d;
  logic       timeout_err;

  // A granted master keeps the bus while its cyc stays high; otherwise re-arbitrate
  // on the same edge so there is no idle bubble between owners.
  always_comb begin
    state_next = arb_pick(wb_I_cyc_i, wb_D_cyc_i, last_was_d);
    case (state)
      ARB_GNT_I: if (wb_I_cyc_i) state_next = ARB_GNT_I;
      ARB_GNT_D: if (wb_D_cyc_i) state_next = ARB_GNT_D;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      last_was_d <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != ARB_IDLE) last_was_d <= (state_next == ARB_GNT_D);
    end
  end

  assign grant_i      = (state == ARB_GNT_I);
  assign grant_d      = (state == ARB_GNT_D);
  assign gnt_o[GNT_I] = grant_i;
  assign gnt_o[GNT_D] = grant_d;

  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    wb_we_o  = 1'b0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    if (grant_i) begin
      wb_adr_o = wb_I_adr_i;
      wb_dat_o = wb_I_dat_i;
      wb_sel_o = wb_I_sel_i;
      wb_we_o  = wb_I_we_i;
      wb_cyc_o = wb_I_cyc_i;
      wb_stb_o = wb_I_cyc_i & wb_I_stb_i;
    end else if (grant_d) begin
      wb_adr_o = wb_D_adr_i;
      wb_dat_o = wb_D_dat_i;
      wb_sel_o = wb_D_sel_i;
      wb_we_o  = wb_D_we_i;
      wb_cyc_o = wb_D_cyc_i;
      wb_stb_o = wb_D_cyc_i & wb_D_stb_i;
    end
  end

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (wb_stb_o & ~wb_ack_i),
    .clear_i (state_next != state),
    .err_o   (timeout_err)
  );

  assign wb_I_dat_o = wb_dat_i;
  assign wb_D_dat_o = wb_dat_i;
  assign wb_I_ack_o = wb_ack_i & grant_i;
  assign wb_D_ack_o = wb_ack_i & grant_d;
  assign wb_I_err_o = timeout_err & grant_i;
  assign wb_D_err_o = timeout_err & grant_d;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: a table of directed cycles, hand-written corner sequences,
// and randomized traffic compared against an owner/last-winner/stall-count model.
module tb_wb_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_adr, i_dat, d_adr, d_dat, s_dat;
  logic [3:0]  i_sel, d_sel;
  logic        i_we, i_cyc, i_stb, d_we, d_cyc, d_stb, s_ack;
  logic [31:0] i_rdat, d_rdat, m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        i_ack, i_err, d_ack, d_err, m_we, m_cyc, m_stb;
  logic [1:0]  gnt;

  int vectors = 0;
  int miscompares = 0;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_I_adr_i(i_adr), .wb_I_dat_i(i_dat), .wb_I_sel_i(i_sel), .wb_I_we_i(i_we),
    .wb_I_cyc_i(i_cyc), .wb_I_stb_i(i_stb), .wb_I_dat_o(i_rdat), .wb_I_ack_o(i_ack),
    .wb_I_err_o(i_err),
    .wb_D_adr_i(d_adr), .wb_D_dat_i(d_dat), .wb_D_sel_i(d_sel), .wb_D_we_i(d_we),
    .wb_D_cyc_i(d_cyc), .wb_D_stb_i(d_stb), .wb_D_dat_o(d_rdat), .wb_D_ack_o(d_ack),
    .wb_D_err_o(d_err),
    .wb_adr_o(m_adr), .wb_dat_o(m_dat), .wb_sel_o(m_sel), .wb_we_o(m_we),
    .wb_cyc_o(m_cyc), .wb_stb_o(m_stb), .wb_dat_i(s_dat), .wb_ack_i(s_ack),
    .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ic, istb, dc, dstb, ack;
    logic [1:0] gnt;
    logic       cyc, iack, dack;
  } vec_t;

  vec_t tbl [19];

  // Model state: owner 0 = none, 1 = I, 2 = D
  int owner, last, stall;

  task automatic chk(input string name, input logic [140:0] got, input logic [140:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_adr = '0; i_dat = '0; i_sel = '0; i_we = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    d_adr = '0; d_dat = '0; d_sel = '0; d_we = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    s_dat = '0; s_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    owner = 0; last = 1; stall = 0;
  endtask

  function automatic logic [140:0] actual();
    return {gnt, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel,
            i_ack, d_ack, i_err, d_err, i_rdat, d_rdat};
  endfunction

  function automatic logic [140:0] model_out(output logic err, output logic stb);
    logic        cyc, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    cyc = 0; stb = 0; we = 0; adr = 0; dat = 0; sel = 0;
    if (owner == 1) begin
      cyc = i_cyc; stb = i_cyc & i_stb; we = i_we; adr = i_adr; dat = i_dat; sel = i_sel;
    end else if (owner == 2) begin
      cyc = d_cyc; stb = d_cyc & d_stb; we = d_we; adr = d_adr; dat = d_dat; sel = d_sel;
    end
    err = (TO > 0) && stb && !s_ack && (stall == TO - 1);
    return {owner == 2, owner == 1, cyc, stb, we, adr, dat, sel,
            s_ack && owner == 1, s_ack && owner == 2,
            err && owner == 1, err && owner == 2, s_dat, s_dat};
  endfunction

  task automatic model_edge(input logic err, input logic stb);
    int nxt;
    if ((owner == 1 && i_cyc) || (owner == 2 && d_cyc)) nxt = owner;
    else if (i_cyc && d_cyc) nxt = (last == 2) ? 1 : 2;
    else if (d_cyc)          nxt = 2;
    else if (i_cyc)          nxt = 1;
    else                     nxt = 0;
    if (nxt != owner)              stall = 0;
    else if (stb && !s_ack && !err) stall = stall + 1;
    else                           stall = 0;
    if (nxt != 0) last = nxt;
    owner = nxt;
  endtask

  initial begin
    int pulses;
    logic e, s;
    logic [140:0] exp;

    // ic istb dc dstb ack | gnt cyc iack dack  (one row per cycle, continuing state)
    tbl = '{
      '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,1'b0,1'b1, 2'b01,1'b1,1'b1,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,1'b1,1'b1, 2'b10,1'b1,1'b0,1'b1},
      '{1'b1,1'b1,1'b1,1'b1,1'b1, 2'b10,1'b1,1'b0,1'b1},
      '{1'b1,1'b1,1'b1,1'b1,1'b1, 2'b10,1'b1,1'b0,1'b1},
      '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,1'b1,1'b0, 2'b01,1'b1,1'b0,1'b0},
      '{1'b0,1'b0,1'b1,1'b1,1'b1, 2'b01,1'b0,1'b1,1'b0},
      '{1'b0,1'b0,1'b1,1'b1,1'b0, 2'b10,1'b1,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0},
      '{1'b0,1'b1,1'b0,1'b0,1'b1, 2'b00,1'b0,1'b0,1'b0},
      '{1'b0,1'b1,1'b0,1'b1,1'b1, 2'b00,1'b0,1'b0,1'b0},
      '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0}
    };

    clear_inputs();
    rst = 1'b1;
    #2;
    chk("reset_outputs", 141'({gnt, m_cyc, m_stb, i_ack, d_ack, i_err, d_err}), 141'(0));
    do_reset();

    for (int k = 0; k < 19; k++) begin
      step();
      i_cyc = tbl[k].ic; i_stb = tbl[k].istb; d_cyc = tbl[k].dc; d_stb = tbl[k].dstb;
      s_ack = tbl[k].ack;
      #1;
      chk($sformatf("table_row%0d", k), 141'({gnt, m_cyc, i_ack, d_ack}),
          141'({tbl[k].gnt, tbl[k].cyc, tbl[k].iack, tbl[k].dack}));
    end

    // I-only read with address and data routing
    do_reset();
    step();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0100;
    step();
    #1;
    chk("i_read_grant", 141'({gnt, m_cyc, m_adr}), 141'({2'b01, 1'b1, 32'h0000_0100}));
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1;
    chk("i_read_ack", 141'({i_ack, i_rdat, d_ack}), 141'({1'b1, 32'hDEAD_BEEF, 1'b0}));

    // Simultaneous request after reset: D first, then direct handoff to I
    do_reset();
    step();
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    step();
    #1;
    chk("tie_d_first", 141'(gnt), 141'(2'b10));
    d_cyc = 1'b0; d_stb = 1'b0;
    step();
    #1;
    chk("handoff_no_idle", 141'(gnt), 141'(2'b01));

    // Timeout: single err pulse on the 16th strobed cycle, D side only
    do_reset();
    step();
    d_cyc = 1'b1; d_stb = 1'b1;
    step();
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (d_err) pulses++;
      chk($sformatf("timeout_c%0d", k), 141'({d_err, i_err}), 141'({k == 16, 1'b0}));
      step();
    end
    chk("timeout_pulse_count", 141'(pulses), 141'(1));

    // Ack on the expiry cycle wins over err
    do_reset();
    step();
    d_cyc = 1'b1; d_stb = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      s_ack = (k == 16);
      #1;
      chk($sformatf("ack_vs_expiry_c%0d", k), 141'({d_err, d_ack}), 141'({1'b0, k == 16}));
      step();
    end

    // Asynchronous reset mid-transfer, then last_gnt back to I
    do_reset();
    step();
    i_cyc = 1'b1; i_stb = 1'b1; s_ack = 1'b1;
    step();
    #1;
    chk("pre_reset_active", 141'({gnt, m_cyc, i_ack}), 141'({2'b01, 1'b1, 1'b1}));
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 141'({gnt, m_cyc, m_stb, i_ack, d_ack, i_err, d_err}), 141'(0));
    clear_inputs();
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    #1;
    chk("post_reset_idle", 141'({gnt, m_cyc}), 141'(0));
    i_cyc = 1'b1; d_cyc = 1'b1;
    step();
    #1;
    chk("post_reset_last_i", 141'(gnt), 141'(2'b10));

    // Randomized traffic against the model; second phase starves acks to hit timeouts
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      step();
      if ($urandom_range(7) == 0) i_cyc = ~i_cyc;
      if ($urandom_range(7) == 0) d_cyc = ~d_cyc;
      i_stb = ($urandom_range(3) != 0);
      d_stb = ($urandom_range(3) != 0);
      i_adr = $urandom; i_dat = $urandom; i_sel = 4'($urandom); i_we = 1'($urandom);
      d_adr = $urandom; d_dat = $urandom; d_sel = 4'($urandom); d_we = 1'($urandom);
      s_dat = $urandom;
      s_ack = (k < 2000) ? 1'($urandom) : ($urandom_range(40) == 0);
      #1;
      exp = model_out(e, s);
      chk($sformatf("random_c%0d", k), actual(), exp);
      model_edge(e, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
